// File: rtl/traffic_phase_ctrl_module.sv
// Two-road intersection phase controller: 1 s tick prescaler, phase FSM,
// seconds countdown for the display path, with pause and night-flash overrides.
module traffic_phase_ctrl_module #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned GREEN_TIME  = 25,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 2
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Pause,
    input  logic       Night_Mode,
    output logic [2:0] Light_A,
    output logic [2:0] Light_B,
    output logic [7:0] Number_Data,
    output logic [2:0] Phase
);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        RED_1 = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        RED_2 = 3'd5,
        NIGHT = 3'd6
    } state_t;

    localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);
    localparam logic [7:0]  GRN_LOAD  = 8'(GREEN_TIME);
    localparam logic [7:0]  YEL_LOAD  = 8'(YELLOW_TIME);
    localparam logic [7:0]  RED_LOAD  = 8'(ALLRED_TIME);

    state_t      state;
    state_t      succ;
    logic [25:0] presc;
    logic        tick;
    logic        flash;

    // Lamp drive for a state, packed as {Light_A, Light_B}
    function automatic logic [5:0] lamps(input state_t s, input logic f);
        case (s)
            A_GRN:   lamps = {3'b001, 3'b100};
            A_YEL:   lamps = {3'b010, 3'b100};
            B_GRN:   lamps = {3'b100, 3'b001};
            B_YEL:   lamps = {3'b100, 3'b010};
            NIGHT:   lamps = {1'b0, f, 1'b0, 1'b0, f, 1'b0};
            default: lamps = {3'b100, 3'b100};
        endcase
    endfunction

    // Countdown load value for a freshly entered state
    function automatic logic [7:0] load_of(input state_t s);
        case (s)
            A_GRN, B_GRN: load_of = GRN_LOAD;
            A_YEL, B_YEL: load_of = YEL_LOAD;
            RED_1, RED_2: load_of = RED_LOAD;
            default:      load_of = '0;
        endcase
    endfunction

    // Tick decode and successor of the current state in the normal cycle
    always_comb begin
        tick = (presc == TICK_LAST);
        case (state)
            A_GRN:   succ = A_YEL;
            A_YEL:   succ = RED_1;
            RED_1:   succ = B_GRN;
            B_GRN:   succ = B_YEL;
            B_YEL:   succ = RED_2;
            default: succ = A_GRN;
        endcase
    end

    // Phase FSM with prescaler, countdown and registered lamp/phase outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state                <= A_GRN;
            presc                <= '0;
            flash                <= 1'b0;
            Number_Data          <= GRN_LOAD;
            {Light_A, Light_B}   <= {3'b001, 3'b100};
            Phase                <= 3'd0;
        end else if (Night_Mode) begin
            if (state != NIGHT) begin
                // Night entry wins over any coincident tick
                state              <= NIGHT;
                presc              <= '0;
                flash              <= 1'b1;
                Number_Data        <= '0;
                {Light_A, Light_B} <= lamps(NIGHT, 1'b1);
                Phase              <= NIGHT;
            end else begin
                presc <= tick ? '0 : presc + 26'd1;
                if (tick) begin
                    flash              <= ~flash;
                    {Light_A, Light_B} <= lamps(NIGHT, ~flash);
                end
            end
        end else if (state == NIGHT) begin
            // Leave night through all-red so the next green is always road A
            state              <= RED_2;
            presc              <= '0;
            flash              <= 1'b0;
            Number_Data        <= RED_LOAD;
            {Light_A, Light_B} <= lamps(RED_2, 1'b0);
            Phase              <= RED_2;
        end else if (!Pause) begin
            presc <= tick ? '0 : presc + 26'd1;
            if (tick) begin
                if (Number_Data == 8'd1) begin
                    state              <= succ;
                    Number_Data        <= load_of(succ);
                    {Light_A, Light_B} <= lamps(succ, 1'b0);
                    Phase              <= succ;
                end else begin
                    Number_Data <= Number_Data - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl_module.sv
// Directed bench for traffic_phase_ctrl_module with a short tick and phases.
module tb_traffic_phase_ctrl_module;

    logic       CLK;
    logic       RSTn;
    logic       Pause;
    logic       Night_Mode;
    logic [2:0] Light_A;
    logic [2:0] Light_B;
    logic [7:0] Number_Data;
    logic [2:0] Phase;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n;

    traffic_phase_ctrl_module #(
        .TICK_DIV    (4),
        .GREEN_TIME  (5),
        .YELLOW_TIME (2),
        .ALLRED_TIME (1)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Pause       (Pause),
        .Night_Mode  (Night_Mode),
        .Light_A     (Light_A),
        .Light_B     (Light_B),
        .Number_Data (Number_Data),
        .Phase       (Phase)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Rising edges since reset release
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, actual, expected, edge_n);
        end
    endtask

    // Expected {Light_A, Light_B} for each timed phase code
    function automatic int exp_lamps(input int ph);
        case (ph)
            0:       return 6'b001_100;
            1:       return 6'b010_100;
            2:       return 6'b100_100;
            3:       return 6'b100_001;
            4:       return 6'b100_010;
            5:       return 6'b100_100;
            default: return -1;
        endcase
    endfunction

    // Every cycle: lamps match the phase, one road red, night lamps amber-only
    always @(negedge CLK) begin
        if (RSTn) begin
            if (Phase == 3'd6) begin
                check("night_same", Light_A, Light_B);
                check("night_amber_only", Light_A & 3'b101, 0);
            end else begin
                check("lamp_decode", {Light_A, Light_B}, exp_lamps(Phase));
                check("one_red", Light_A[2] | Light_B[2], 1);
            end
        end
    end

    task automatic wait_edge(input int n);
        while (edge_n < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        Pause      = 1'b0;
        Night_Mode = 1'b0;
        RSTn       = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and one full normal cycle
        Pause = 1'b0; Night_Mode = 1'b0; RSTn = 1'b0;
        @(negedge CLK);
        check("rst_phase", Phase, 0);
        check("rst_la", Light_A, 3'b001);
        check("rst_lb", Light_B, 3'b100);
        check("rst_nd", Number_Data, 5);
        @(negedge CLK);
        RSTn = 1'b1;
        wait_edge(3);  check("e3_nd", Number_Data, 5);
        wait_edge(4);  check("e4_nd", Number_Data, 4);
        wait_edge(19); check("e19_nd", Number_Data, 1); check("e19_ph", Phase, 0);
        wait_edge(20); check("e20_ph", Phase, 1); check("e20_la", Light_A, 3'b010);
                       check("e20_nd", Number_Data, 2);
        wait_edge(28); check("e28_ph", Phase, 2); check("e28_nd", Number_Data, 1);
        wait_edge(32); check("e32_ph", Phase, 3); check("e32_lb", Light_B, 3'b001);
                       check("e32_nd", Number_Data, 5);
        wait_edge(52); check("e52_ph", Phase, 4); check("e52_nd", Number_Data, 2);
        wait_edge(60); check("e60_ph", Phase, 5); check("e60_nd", Number_Data, 1);
        wait_edge(63); check("e63_ph", Phase, 5);
        wait_edge(64); check("e64_ph", Phase, 0); check("e64_nd", Number_Data, 5);
                       check("e64_la", Light_A, 3'b001);

        // Pause sampled on edges 6..15, resumes from the held prescaler
        do_reset();
        wait_edge(5);  Pause = 1'b1;
        wait_edge(10); check("pause_nd10", Number_Data, 4); check("pause_ph10", Phase, 0);
        wait_edge(15); check("pause_nd15", Number_Data, 4); Pause = 1'b0;
        wait_edge(17); check("pause_nd17", Number_Data, 4);
        wait_edge(18); check("pause_nd18", Number_Data, 3);

        // Night entry from B_GRN, flashing, pause ignored, exit through RED_2
        do_reset();
        wait_edge(33); check("pre_night_ph", Phase, 3); Night_Mode = 1'b1;
        wait_edge(34); check("night_ph", Phase, 6); check("night_la", Light_A, 3'b010);
                       check("night_lb", Light_B, 3'b010); check("night_nd", Number_Data, 0);
        wait_edge(37); check("night_la37", Light_A, 3'b010);
        wait_edge(38); check("night_la38", Light_A, 3'b000); check("night_lb38", Light_B, 3'b000);
                       Pause = 1'b1;
        wait_edge(41); check("night_la41", Light_A, 3'b000);
        wait_edge(42); check("night_la42", Light_A, 3'b010);
                       Night_Mode = 1'b0; Pause = 1'b0;
        wait_edge(43); check("exit_ph", Phase, 5); check("exit_la", Light_A, 3'b100);
                       check("exit_lb", Light_B, 3'b100); check("exit_nd", Number_Data, 1);
        wait_edge(46); check("exit_ph46", Phase, 5);
        wait_edge(47); check("exit_ph47", Phase, 0); check("exit_nd47", Number_Data, 5);
                       check("exit_la47", Light_A, 3'b001);

        // Night rise coincident with a tick discards the countdown
        do_reset();
        wait_edge(3);  Night_Mode = 1'b1;
        wait_edge(4);  check("coinc_ph", Phase, 6); check("coinc_nd", Number_Data, 0);
                       check("coinc_la", Light_A, 3'b010);
                       Night_Mode = 1'b0;
        wait_edge(5);  check("coinc_exit_ph", Phase, 5); check("coinc_exit_nd", Number_Data, 1);
        wait_edge(9);  check("coinc_ag_ph", Phase, 0); check("coinc_ag_nd", Number_Data, 5);

        // Asynchronous reset in the middle of B_YEL
        do_reset();
        wait_edge(54); check("byel_ph", Phase, 4);
        RSTn = 1'b0;
        #1;
        check("arst_ph", Phase, 0);
        check("arst_la", Light_A, 3'b001);
        check("arst_lb", Light_B, 3'b100);
        check("arst_nd", Number_Data, 5);
        @(negedge CLK);
        RSTn = 1'b1;
        wait_edge(4);  check("arst_e4_nd", Number_Data, 4);
        wait_edge(20); check("arst_e20_ph", Phase, 1); check("arst_e20_nd", Number_Data, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
